// File: rtl/match_controller.sv
// -----------------------------------------------------------------------------
// match_controller
//
// Pong match sequencer placed between the frame-tick source and the ball
// datapath. It decides when the ball may move (idle, serve countdown, live
// play, pause, post-point freeze, game over), watches both score counters,
// declares a winner and issues a one-cycle clear pulse that restarts the ball
// datapath and its scores.
//
// Parameters
//   WIN_SCORE     score (6-bit compare) at which a player wins, 1..63
//   SERVE_FRAMES  refresh ticks of countdown before play starts, 1..127
//   POINT_FRAMES  refresh ticks of freeze after a point is scored, 1..127
//
// Ports
//   clk            in   system clock
//   reset          in   asynchronous, active-low reset (0 = reset)
//   refresh_tick   in   one-cycle pulse per video frame
//   btn_start      in   start button level, already synchronised
//   btn_pause      in   pause button level, already synchronised
//   score_player1  in   [5:0] player-1 score from the ball datapath
//   score_player2  in   [5:0] player-2 score from the ball datapath
//   ball_tick      out  refresh_tick gated by live play (combinational)
//   match_clear    out  one-cycle pulse resetting the ball datapath
//   state          out  [2:0] current sequencer state encoding
//   serve_count    out  [6:0] frames left in the current SERVE/POINT wait
//   winner         out  [1:0] 00 none, 01 player1, 10 player2
// -----------------------------------------------------------------------------
module match_controller #(
    parameter int unsigned WIN_SCORE    = 7,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned POINT_FRAMES = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       refresh_tick,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic [5:0] score_player1,
    input  logic [5:0] score_player2,
    output logic       ball_tick,
    output logic       match_clear,
    output logic [2:0] state,
    output logic [6:0] serve_count,
    output logic [1:0] winner
);

    localparam logic [5:0] WIN_L   = 6'(WIN_SCORE);
    localparam logic [6:0] SERVE_L = 7'(SERVE_FRAMES);
    localparam logic [6:0] POINT_L = 7'(POINT_FRAMES);

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_POINT = 3'd4,
        ST_OVER  = 3'd5
    } state_e;

    // Registered state and outputs
    state_e     state_q,       state_d;
    logic [6:0] count_q,       count_d;
    logic [1:0] winner_q,      winner_d;
    logic       clear_q,       clear_d;

    // Input history: button levels and scores from the previous clock
    logic       start_prev_q;
    logic       pause_prev_q;
    logic [5:0] prev1_q;
    logic [5:0] prev2_q;

    logic       start_edge;
    logic       pause_edge;
    logic       score_evt;
    logic       p1_wins;
    logic       p2_wins;
    logic       count_last;

    // The history registers clear to 0 in reset, so a button held through
    // reset release produces exactly one edge on the first clock afterwards.
    assign start_edge = btn_start & ~start_prev_q;
    assign pause_edge = btn_pause & ~pause_prev_q;

    // Any score movement is a candidate point; it only counts while in PLAY,
    // which is what keeps the datapath clear-to-zero from being scored.
    assign score_evt  = (score_player1 != prev1_q) | (score_player2 != prev2_q);

    assign p1_wins    = (score_player1 >= WIN_L);
    assign p2_wins    = (score_player2 >= WIN_L);

    // Treat 0 like 1 so the countdown can never underflow or stall.
    assign count_last = (count_q <= 7'd1);

    // Only the ball tick is combinational: the datapath must see the frame
    // pulse in the same cycle it arrives.
    assign ball_tick   = refresh_tick & (state_q == ST_PLAY);

    assign match_clear = clear_q;
    assign state       = state_q;
    assign serve_count = count_q;
    assign winner      = winner_q;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        winner_d = winner_q;
        clear_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    clear_d = 1'b1;
                    count_d = SERVE_L;
                    state_d = ST_SERVE;
                end
            end

            ST_SERVE: begin
                if (refresh_tick) begin
                    if (count_last) begin
                        count_d = 7'd0;
                        state_d = ST_PLAY;
                    end else begin
                        count_d = count_q - 7'd1;
                    end
                end
            end

            ST_PLAY: begin
                // A point outranks a pause press arriving in the same clock;
                // player 1 is checked first when both reach the win score.
                if (score_evt) begin
                    if (p1_wins) begin
                        winner_d = WIN_P1;
                        state_d  = ST_OVER;
                    end else if (p2_wins) begin
                        winner_d = WIN_P2;
                        state_d  = ST_OVER;
                    end else begin
                        count_d  = POINT_L;
                        state_d  = ST_POINT;
                    end
                end else if (pause_edge) begin
                    state_d = ST_PAUSE;
                end
            end

            ST_PAUSE: begin
                if (pause_edge) begin
                    state_d = ST_PLAY;
                end
            end

            ST_POINT: begin
                if (refresh_tick) begin
                    if (count_last) begin
                        count_d = SERVE_L;
                        state_d = ST_SERVE;
                    end else begin
                        count_d = count_q - 7'd1;
                    end
                end
            end

            ST_OVER: begin
                if (start_edge) begin
                    clear_d  = 1'b1;
                    winner_d = WIN_NONE;
                    count_d  = SERVE_L;
                    state_d  = ST_SERVE;
                end
            end

            // Unused encodings recover to IDLE on the next clock.
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            count_q      <= 7'd0;
            winner_q     <= WIN_NONE;
            clear_q      <= 1'b0;
            start_prev_q <= 1'b0;
            pause_prev_q <= 1'b0;
            prev1_q      <= 6'd0;
            prev2_q      <= 6'd0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            winner_q     <= winner_d;
            clear_q      <= clear_d;
            start_prev_q <= btn_start;
            pause_prev_q <= btn_pause;
            prev1_q      <= score_player1;
            prev2_q      <= score_player2;
        end
    end

endmodule

// File: tb/tb_match_controller.sv
module tb_match_controller;

    logic       clk;
    logic       reset;
    logic       refresh_tick;
    logic       btn_start;
    logic       btn_pause;
    logic [5:0] score_player1;
    logic [5:0] score_player2;
    logic       ball_tick;
    logic       match_clear;
    logic [2:0] state;
    logic [6:0] serve_count;
    logic [1:0] winner;

    int checks = 0;
    int errors = 0;

    match_controller #(
        .WIN_SCORE   (7),
        .SERVE_FRAMES(60),
        .POINT_FRAMES(30)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .refresh_tick (refresh_tick),
        .btn_start    (btn_start),
        .btn_pause    (btn_pause),
        .score_player1(score_player1),
        .score_player2(score_player2),
        .ball_tick    (ball_tick),
        .match_clear  (match_clear),
        .state        (state),
        .serve_count  (serve_count),
        .winner       (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       tick;
        logic       start;
        logic       pause;
        logic [5:0] s1;
        logic [5:0] s2;
        int         rep;
        logic [2:0] e_state;
        logic [6:0] e_cnt;
        logic [1:0] e_win;
        logic       e_clr;
        logic       e_bt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic tick, input logic start, input logic pause,
                       input logic [5:0] s1, input logic [5:0] s2, input int rep,
                       input logic [2:0] e_state, input logic [6:0] e_cnt,
                       input logic [1:0] e_win, input logic e_clr, input logic e_bt);
        vec_t v;
        v.tick = tick; v.start = start; v.pause = pause; v.s1 = s1; v.s2 = s2;
        v.rep = rep; v.e_state = e_state; v.e_cnt = e_cnt; v.e_win = e_win;
        v.e_clr = e_clr; v.e_bt = e_bt;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_regs(input string nm, input logic [2:0] st, input logic [6:0] cnt,
                            input logic [1:0] win, input logic clr);
        chk({nm, ".state"},  {29'd0, state},       {29'd0, st});
        chk({nm, ".count"},  {25'd0, serve_count}, {25'd0, cnt});
        chk({nm, ".winner"}, {30'd0, winner},      {30'd0, win});
        chk({nm, ".clear"},  {31'd0, match_clear}, {31'd0, clr});
    endtask

    // Watchdog: the run is a few thousand cycles; anything longer is a hang.
    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; refresh_tick = 1'b0; btn_start = 1'b0; btn_pause = 1'b0;
        score_player1 = 6'd0; score_player2 = 6'd0;

        //   tick st pa s1 s2 rep  state cnt win clr bt
        add(0, 0, 0, 6, 3,  1,   0,  0, 0, 0, 0);  // idle after reset
        add(0, 1, 0, 6, 3,  1,   1, 60, 0, 1, 0);  // start edge
        add(0, 1, 0, 6, 3,  1,   1, 60, 0, 0, 0);  // clear lasts one clk
        add(0, 0, 0, 6, 3,  1,   1, 60, 0, 0, 0);
        add(1, 0, 0, 6, 3, 59,   1,  1, 0, 0, 0);  // countdown
        add(1, 0, 0, 6, 3,  1,   2,  0, 0, 0, 0);  // 60th tick -> play
        add(1, 0, 0, 6, 3,  3,   2,  0, 0, 0, 1);  // ball_tick echoes
        add(0, 0, 0, 6, 4,  1,   4, 30, 0, 0, 0);  // p2 scores
        add(1, 0, 0, 6, 4, 29,   4,  1, 0, 0, 0);
        add(1, 0, 0, 6, 4,  1,   1, 60, 0, 0, 0);  // freeze over -> serve
        add(1, 0, 0, 6, 4, 60,   2,  0, 0, 0, 0);
        add(0, 0, 1, 6, 4,  1,   3,  0, 0, 0, 0);  // pause
        add(1, 0, 1, 6, 4, 10,   3,  0, 0, 0, 0);  // ticks ignored in pause
        add(0, 0, 0, 6, 4,  1,   3,  0, 0, 0, 0);
        add(0, 0, 1, 6, 4,  1,   2,  0, 0, 0, 0);  // resume
        add(1, 0, 0, 6, 4,  2,   2,  0, 0, 0, 1);
        add(0, 0, 1, 6, 5,  1,   4, 30, 0, 0, 0);  // score beats pause
        add(1, 0, 0, 6, 5, 30,   1, 60, 0, 0, 0);
        add(1, 0, 0, 6, 5, 60,   2,  0, 0, 0, 0);
        add(0, 1, 0, 6, 5,  1,   2,  0, 0, 0, 0);  // start ignored in play
        add(0, 0, 0, 7, 5,  1,   5,  0, 1, 0, 0);  // p1 reaches 7
        add(1, 0, 0, 7, 5,  3,   5,  0, 1, 0, 0);  // winner held
        add(0, 1, 0, 7, 5,  1,   1, 60, 0, 1, 0);  // restart
        add(0, 0, 0, 0, 0,  1,   1, 60, 0, 0, 0);  // clear to 0 not a point
        add(1, 0, 0, 0, 0, 60,   2,  0, 0, 0, 0);
        add(0, 0, 0, 0, 7,  1,   5,  0, 2, 0, 0);  // p2 wins
        add(0, 1, 0, 0, 7,  1,   1, 60, 0, 1, 0);
        add(1, 0, 0, 0, 7, 60,   2,  0, 0, 0, 0);
        add(0, 0, 0, 8, 8,  1,   5,  0, 1, 0, 0);  // both qualify -> p1
        add(1, 0, 0, 8, 8,  1,   5,  0, 1, 0, 0);
        add(0, 0, 0, 0, 0,  1,   5,  0, 1, 0, 0);
        add(0, 1, 0, 0, 0,  1,   1, 60, 0, 1, 0);
        add(1, 0, 0, 0, 0, 60,   2,  0, 0, 0, 0);
        add(0, 0, 0, 1, 0,  1,   4, 30, 0, 0, 0);
        add(1, 0, 0, 1, 0,  2,   4, 28, 0, 0, 0);

        // Reset state, checked before any clock edge
        #3;
        chk_regs("reset0", 3'd0, 7'd0, 2'b00, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].rep; r++) begin
                @(negedge clk);
                refresh_tick  = vecs[i].tick;
                btn_start     = vecs[i].start;
                btn_pause     = vecs[i].pause;
                score_player1 = vecs[i].s1;
                score_player2 = vecs[i].s2;
                #1;
                chk($sformatf("v%0d.ball_tick", i), {31'd0, ball_tick}, {31'd0, vecs[i].e_bt});
                @(posedge clk);
                #1;
                if (r == vecs[i].rep - 1)
                    chk_regs($sformatf("v%0d", i), vecs[i].e_state, vecs[i].e_cnt,
                             vecs[i].e_win, vecs[i].e_clr);
            end
        end

        // Asynchronous reset mid-freeze, with start held through release
        @(negedge clk);
        refresh_tick = 1'b0;
        #2;
        reset = 1'b0;
        btn_start = 1'b1;
        #1;
        chk_regs("async_rst", 3'd0, 7'd0, 2'b00, 1'b0);
        @(posedge clk);
        #1;
        chk_regs("in_rst", 3'd0, 7'd0, 2'b00, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_regs("held_start_edge", 3'd1, 7'd60, 2'b00, 1'b1);
        @(posedge clk);
        #1;
        chk_regs("held_start_once", 3'd1, 7'd60, 2'b00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
